id_alu_issue: RTL and testbench
===============================

# id_alu_issue

Instruction-decode issue stage for the 5-stage MIPS pipeline without forwarding.
- Decodes the IF/ID instruction into the 4-bit ALU control code and operands consumed by the EX-stage ALU, and registers them into the ID/EX pipeline register.
- Stalls on read-after-write hazards using an internal scoreboard of in-flight destinations.
- Inserts bubbles on stall or flush.

## Interface
Parameters:
- SB_DEPTH, 3, number of in-flight stages tracked (EX, MEM, WB); fixed by the no-bypass register file.

Ports (clock: one clock `clk`; reset: `rst`, synchronous, active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  IF/ID holds a valid instruction
- if_inst  in  32  instruction word
- if_ready  out  1  ID consumes the instruction this cycle (combinational)
- flush  in  1  squash the instruction in ID (branch redirect)
- rs_addr  out  5  register-file read address, = if_inst[25:21] (combinational)
- rt_addr  out  5  register-file read address, = if_inst[20:16] (combinational)
- rs_data  in  32  register-file read data for rs
- rt_data  in  32  register-file read data for rt
- ex_valid  out  1  ID/EX holds a real instruction
- ex_aluctr  out  4  ALU control code
- ex_a  out  32  ALU operand A
- ex_b  out  32  ALU operand B
- ex_shamt  out  5  shift amount, = inst[10:6]
- ex_rd  out  5  destination register
- ex_regwrite  out  1  destination write enable
- illegal_inst  out  1  sticky unsupported-opcode flag (only with ILLEGAL_TRAP_EN)

## Operation
ALU control codes:
- 0 = nop
- 1 = add, 2 = sub, 3 = and, 4 = or, 5 = xor, 6 = lui
- 7 = slt, 8 = sltu, 9 = nor, 10 = sll, 11 = srl, 12 = sra

Decode:
- R-type (op 0): add/addu→1, sub/subu→2, and→3, or→4, xor→5, nor→9, slt→7, sltu→8; sources rs, rt; dest rd.
- Shifts sll/srl/sra→10/11/12; A=0, B=rt_data; source rt only; dest rd.
- I-type; B=imm; source rs; dest rt:
  - addi/addiu→1, sign-extended imm.
  - slti→7, sltiu→8, sign-extended imm.
  - andi→3, ori→4, xori→5, zero-extended imm.
- lui→6; B={16'b0, imm}; no sources; dest rt.
- Dest $0: ex_regwrite=0.
- Unsupported opcode/funct: see Configuration.

Hazard scoreboard:
- SB_DEPTH entries of {valid, addr}.
- Shifts every cycle, including stall cycles; entry 0 loads the issued destination, or invalid on bubble.
- Hazard when any used source is nonzero and equals a valid entry's addr.

Per-cycle priority:
1. rst: ID/EX and scoreboard cleared.
2. flush: if_ready=1 (instruction dropped), bubble issued.
3. if_valid & hazard: if_ready=0, bubble issued.
4. if_valid: if_ready=1, instruction issued.
5. else: bubble.

A bubble sets ex_valid=0, ex_aluctr=0, ex_regwrite=0. ex_a/ex_b hold don't-care but are driven to 0.

## Timing
- Reset: all ex_* outputs 0, illegal_inst 0, scoreboard empty; if_ready = if_valid & ~hazard after reset.
- Latency: instruction in ID at cycle n appears on ex_* in cycle n+1.
- Back-to-back dependence (I2 reads I1's dest) costs 3 stall cycles; I2 issues 4 cycles after I1.
- Distance-2 dependence costs 2 stalls; distance 3 costs 1; distance ≥4 costs none.
- A flush during a stall releases the stall immediately. The scoreboard keeps its entries, because older instructions still complete.
- rst mid-stall: stall cleared next cycle, pending scoreboard entries dropped.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - Unsupported instruction issues a bubble and sets illegal_inst.
  - illegal_inst stays set and holds if_ready=0 until rst.
- Undefined: unsupported instruction issues as a bubble with if_ready=1; illegal_inst tied 0.

## Structure
- Shared package: ALU control code constants (0–12), opcode and funct constants, scoreboard entry typedef.
- One sub-module, `id_hazard_sb`:
  - Inputs: source addresses plus use flags, issue dest/valid.
  - Output: hazard.

## Test plan
- Reset: assert rst 2 cycles with if_valid=1 → ex_valid=0, ex_aluctr=0; first issue after release.
- `addi $1,$0,5` then `add $2,$1,$1` → add stalls 3 cycles; issued with ex_aluctr=1 and ex_a=ex_b=5 (regfile model).
- `lui $3,0x1234` → ex_aluctr=6, ex_b=0x00001234, no stall even with $3 pending.
- `sra $4,$5,3` with $5=0x80000000 → ex_aluctr=12, ex_shamt=3, ex_b=0x80000000; rs ignored for hazard.
- `ori $6,$0,0xFFFF` → ex_b=0x0000FFFF. `slti $7,$0,-1` → ex_b=0xFFFFFFFF, ex_aluctr=7.
- Stalled `add` plus flush pulse → bubble, if_ready=1, no issue. Opcode 0x3F → illegal_inst=1 only with ILLEGAL_TRAP_EN.

Source files
------------

// File: rtl/id_alu_issue_pkg.sv
// Shared decode constants for the ID issue stage: ALU control codes, MIPS
// opcode/funct values, the scoreboard entry and the ID/EX register bundle.
package id_alu_issue_pkg;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_LUI  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_NOR  = 4'd9,
    ALU_SLL  = 4'd10,
    ALU_SRL  = 4'd11,
    ALU_SRA  = 4'd12
  } alu_ctr_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
  } sb_entry_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  aluctr;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic        regwrite;
  } ex_bundle_t;

endpackage

// File: rtl/id_alu_issue_if.sv
// ID/EX pipeline-register bus: the issue stage drives it (master), the
// EX-stage ALU consumes it (slave).
interface id_alu_issue_if;
  logic        ex_valid;
  logic [3:0]  ex_aluctr;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [4:0]  ex_shamt;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;

  modport master (
    output ex_valid, ex_aluctr, ex_a, ex_b, ex_shamt, ex_rd, ex_regwrite
  );
  modport slave (
    input ex_valid, ex_aluctr, ex_a, ex_b, ex_shamt, ex_rd, ex_regwrite
  );
endinterface

// File: rtl/id_alu_issue_hazard_sb.sv
// In-flight destination scoreboard (EX/MEM/WB); flags a read-after-write
// hazard for any used, nonzero source that matches a pending destination.
module id_hazard_sb
  import id_alu_issue_pkg::*;
#(
  parameter int SB_DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_addr_i,
  input  logic       rs_use_i,
  input  logic [4:0] rt_addr_i,
  input  logic       rt_use_i,
  input  logic       issue_valid_i,
  input  logic [4:0] issue_dest_i,
  output logic       hazard_o
);

  sb_entry_t sb_q [SB_DEPTH];

  // Shifts every cycle, stalls included, so pending writes age out on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the scoreboard array is tiny control state and every entry must
      // come out of reset invalid, so each one is cleared explicitly.
      for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let the shift read every old entry
      // before any of them is overwritten.
      sb_q[0] <= '{valid: issue_valid_i, addr: issue_dest_i};
      for (int i = 1; i < SB_DEPTH; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_q[i].valid) begin
        if (rs_use_i && (rs_addr_i != 5'd0) && (rs_addr_i == sb_q[i].addr)) hazard_o = 1'b1;
        if (rt_use_i && (rt_addr_i != 5'd0) && (rt_addr_i == sb_q[i].addr)) hazard_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_alu_issue.sv
// MIPS ID issue stage: decodes IF/ID into ALU control and operands, stalls on
// RAW hazards, registers ID/EX. Optional ILLEGAL_TRAP_EN makes illegal_inst sticky.
module id_alu_issue
  import id_alu_issue_pkg::*;
#(
  parameter int SB_DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [31:0]            if_inst,
  output logic                   if_ready,
  input  logic                   flush,
  output logic [4:0]             rs_addr,
  output logic [4:0]             rt_addr,
  input  logic [31:0]            rs_data,
  input  logic [31:0]            rt_data,
  id_alu_issue_if.master         ex,
  output logic                   illegal_inst
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rd, shamt;
  logic [15:0] imm;
  alu_ctr_e    aluctr;
  logic        use_rs, use_rt, legal, shift;
  logic [4:0]  dest;
  logic [31:0] op_a, op_b;
  logic        hazard, issue;
  ex_bundle_t  ex_d, ex_q;

  assign opcode  = if_inst[31:26];
  assign rs_addr = if_inst[25:21];
  assign rt_addr = if_inst[20:16];
  assign rd      = if_inst[15:11];
  assign shamt   = if_inst[10:6];
  assign funct   = if_inst[5:0];
  assign imm     = if_inst[15:0];

  always_comb begin
    // NOTE: every decode output gets a default first so no path infers a latch.
    aluctr = ALU_NOP;
    use_rs = 1'b0;
    use_rt = 1'b0;
    shift  = 1'b0;
    legal  = 1'b1;
    dest   = 5'd0;
    op_a   = '0;
    op_b   = '0;
    case (opcode)
      OP_RTYPE: begin
        dest   = rd;
        use_rs = 1'b1;
        use_rt = 1'b1;
        op_a   = rs_data;
        op_b   = rt_data;
        case (funct)
          FN_ADD, FN_ADDU: aluctr = ALU_ADD;
          FN_SUB, FN_SUBU: aluctr = ALU_SUB;
          FN_AND:          aluctr = ALU_AND;
          FN_OR:           aluctr = ALU_OR;
          FN_XOR:          aluctr = ALU_XOR;
          FN_NOR:          aluctr = ALU_NOR;
          FN_SLT:          aluctr = ALU_SLT;
          FN_SLTU:         aluctr = ALU_SLTU;
          FN_SLL: begin aluctr = ALU_SLL; shift = 1'b1; end
          FN_SRL: begin aluctr = ALU_SRL; shift = 1'b1; end
          FN_SRA: begin aluctr = ALU_SRA; shift = 1'b1; end
          default:         legal  = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        dest   = rt_addr;
        use_rs = 1'b1;
        op_a   = rs_data;
        op_b   = {{16{imm[15]}}, imm};
        aluctr = (opcode == OP_SLTI)  ? ALU_SLT  :
                 (opcode == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dest   = rt_addr;
        use_rs = 1'b1;
        op_a   = rs_data;
        op_b   = {16'h0000, imm};
        aluctr = (opcode == OP_ANDI) ? ALU_AND :
                 (opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: begin
        dest   = rt_addr;
        op_b   = {16'h0000, imm};
        aluctr = ALU_LUI;
      end
      default: legal = 1'b0;
    endcase
    // Shifts take only rt: rs is a don't-care field and must not stall.
    if (shift) begin
      use_rs = 1'b0;
      op_a   = '0;
    end
    if (!legal) begin
      use_rs = 1'b0;
      use_rt = 1'b0;
      dest   = 5'd0;
      op_a   = '0;
      op_b   = '0;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, trap_set;
`endif

  always_comb begin
    if_ready = 1'b0;
    issue    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    trap_set = 1'b0;
`endif
    if (rst) begin
      if_ready = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    end else if (illegal_q) begin
      if_ready = 1'b0;
`endif
    end else if (flush) begin
      if_ready = 1'b1;
    end else if (if_valid && hazard) begin
      if_ready = 1'b0;
    end else if (if_valid && !legal) begin
`ifdef ILLEGAL_TRAP_EN
      trap_set = 1'b1;
`else
      if_ready = 1'b1;
`endif
    end else if (if_valid) begin
      if_ready = 1'b1;
      issue    = 1'b1;
    end
  end

  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.valid    = 1'b1;
      ex_d.aluctr   = aluctr;
      ex_d.a        = op_a;
      ex_d.b        = op_b;
      ex_d.shamt    = shamt;
      ex_d.rd       = dest;
      ex_d.regwrite = (dest != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_q | trap_set;
  end
  assign illegal_inst = illegal_q;
`else
  assign illegal_inst = 1'b0;
`endif

  id_hazard_sb #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk           (clk),
    .rst           (rst),
    .rs_addr_i     (rs_addr),
    .rs_use_i      (use_rs),
    .rt_addr_i     (rt_addr),
    .rt_use_i      (use_rt),
    .issue_valid_i (ex_d.regwrite),
    .issue_dest_i  (ex_d.rd),
    .hazard_o      (hazard)
  );

  assign ex.ex_valid    = ex_q.valid;
  assign ex.ex_aluctr   = ex_q.aluctr;
  assign ex.ex_a        = ex_q.a;
  assign ex.ex_b        = ex_q.b;
  assign ex.ex_shamt    = ex_q.shamt;
  assign ex.ex_rd       = ex_q.rd;
  assign ex.ex_regwrite = ex_q.regwrite;

endmodule

// File: tb/tb_id_alu_issue.sv
// Directed bench for id_alu_issue: regfile with a 3-stage writeback model,
// hand-computed decode results and stall counts.
module tb_id_alu_issue;
  import id_alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, if_ready, illegal_inst;
  logic [31:0] if_inst, rs_data, rt_data;
  logic [4:0]  rs_addr, rt_addr;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          stalls;

  id_alu_issue_if ex_bus ();

  id_alu_issue dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_inst      (if_inst),
    .if_ready     (if_ready),
    .flush        (flush),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .ex           (ex_bus),
    .illegal_inst (illegal_inst)
  );

  always #5 clk = ~clk;

  // Register file plus EX->MEM->WB delay; a WB write is visible the next cycle.
  logic [31:0] regs [32];
  logic        rf_clear = 1'b1;
  logic        mem_v, wb_v;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_val, wb_val;

  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];

  function automatic logic [31:0] tb_alu(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    case (c)
      4'd1:  return a + b;
      4'd2:  return a - b;
      4'd3:  return a & b;
      4'd4:  return a | b;
      4'd5:  return a ^ b;
      4'd6:  return b << 16;
      4'd7:  return {31'd0, $signed(a) < $signed(b)};
      4'd8:  return {31'd0, a < b};
      4'd9:  return ~(a | b);
      4'd10: return b << sh;
      4'd11: return b >> sh;
      4'd12: return $signed(b) >>> sh;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      regs[5] <= 32'h8000_0000;
      mem_v <= 1'b0;
      wb_v  <= 1'b0;
    end else begin
      mem_v   <= ex_bus.ex_valid & ex_bus.ex_regwrite;
      mem_rd  <= ex_bus.ex_rd;
      mem_val <= tb_alu(ex_bus.ex_aluctr, ex_bus.ex_a, ex_bus.ex_b, ex_bus.ex_shamt);
      wb_v    <= mem_v;
      wb_rd   <= mem_rd;
      wb_val  <= mem_val;
      if (wb_v && wb_rd != 5'd0) regs[wb_rd] <= wb_val;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {OP_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, count stall cycles (bounded), leave it on ex_*.
  task automatic present(input logic [31:0] inst, output int n_stall);
    if_valid = 1'b1;
    if_inst  = inst;
    n_stall  = 0;
    #1;
    while (!if_ready && n_stall < 10) begin
      tick();
      n_stall++;
    end
    tick();
    if_valid = 1'b0;
    if_inst  = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    if_valid = 1'b1;
    if_inst  = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_valid", ex_bus.ex_valid, 0);
    check("rst_ex_aluctr", ex_bus.ex_aluctr, 0);
    check("rst_ex_a", ex_bus.ex_a, 0);
    check("rst_illegal", illegal_inst, 0);
    rst      = 1'b0;
    rf_clear = 1'b0;

    present(enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5), stalls);
    check("addi_stalls", stalls, 0);
    check("addi_valid", ex_bus.ex_valid, 1);
    check("addi_aluctr", ex_bus.ex_aluctr, 1);
    check("addi_b", ex_bus.ex_b, 32'd5);
    check("addi_rd", ex_bus.ex_rd, 1);
    check("addi_regwrite", ex_bus.ex_regwrite, 1);

    present(enc_r(FN_ADD, 5'd1, 5'd1, 5'd2, 5'd0), stalls);
    check("add_b2b_stalls", stalls, 3);
    check("add_aluctr", ex_bus.ex_aluctr, 1);
    check("add_a", ex_bus.ex_a, 32'd5);
    check("add_b", ex_bus.ex_b, 32'd5);
    check("add_rd", ex_bus.ex_rd, 2);
    tick();
    check("bubble_valid", ex_bus.ex_valid, 0);
    check("bubble_aluctr", ex_bus.ex_aluctr, 0);
    check("bubble_regwrite", ex_bus.ex_regwrite, 0);

    present(enc_i(OP_ORI, 5'd0, 5'd3, 16'd7), stalls);
    present(enc_i(OP_LUI, 5'd0, 5'd3, 16'h1234), stalls);
    check("lui_stalls", stalls, 0);
    check("lui_aluctr", ex_bus.ex_aluctr, 6);
    check("lui_b", ex_bus.ex_b, 32'h0000_1234);
    check("lui_rd", ex_bus.ex_rd, 3);

    present(enc_r(FN_SRA, 5'd3, 5'd5, 5'd4, 5'd3), stalls);
    check("sra_stalls", stalls, 0);
    check("sra_aluctr", ex_bus.ex_aluctr, 12);
    check("sra_shamt", ex_bus.ex_shamt, 3);
    check("sra_a", ex_bus.ex_a, 0);
    check("sra_b", ex_bus.ex_b, 32'h8000_0000);

    present(enc_i(OP_ORI, 5'd0, 5'd6, 16'hFFFF), stalls);
    check("ori_aluctr", ex_bus.ex_aluctr, 4);
    check("ori_b", ex_bus.ex_b, 32'h0000_FFFF);
    present(enc_i(OP_SLTI, 5'd0, 5'd7, 16'hFFFF), stalls);
    check("slti_aluctr", ex_bus.ex_aluctr, 7);
    check("slti_b", ex_bus.ex_b, 32'hFFFF_FFFF);

    present(enc_i(OP_ADDI, 5'd0, 5'd0, 16'd1), stalls);
    check("r0_valid", ex_bus.ex_valid, 1);
    check("r0_regwrite", ex_bus.ex_regwrite, 0);

    present(enc_i(OP_ORI, 5'd0, 5'd8, 16'd1), stalls);
    present(enc_i(OP_ORI, 5'd0, 5'd9, 16'd2), stalls);
    present(enc_r(FN_ADD, 5'd8, 5'd0, 5'd10, 5'd0), stalls);
    check("dist2_stalls", stalls, 2);

    present(enc_r(FN_SUB, 5'd6, 5'd7, 5'd16, 5'd0), stalls);
    check("sub_stalls", stalls, 0);
    check("sub_aluctr", ex_bus.ex_aluctr, 2);
    check("sub_a", ex_bus.ex_a, 32'h0000_FFFF);
    check("sub_b", ex_bus.ex_b, 32'd0);

    // Flush while stalled: dropped as a bubble, older entries still pending.
    present(enc_i(OP_ORI, 5'd0, 5'd11, 16'd3), stalls);
    if_valid = 1'b1;
    if_inst  = enc_r(FN_ADD, 5'd11, 5'd11, 5'd12, 5'd0);
    #1;
    check("flush_pre_ready", if_ready, 0);
    tick();
    flush = 1'b1;
    #1;
    check("flush_ready", if_ready, 1);
    tick();
    flush    = 1'b0;
    if_valid = 1'b0;
    check("flush_bubble_valid", ex_bus.ex_valid, 0);
    check("flush_bubble_aluctr", ex_bus.ex_aluctr, 0);
    present(enc_r(FN_ADD, 5'd11, 5'd0, 5'd13, 5'd0), stalls);
    check("flush_sb_kept_stalls", stalls, 1);
    check("after_flush_rd", ex_bus.ex_rd, 13);

    // Reset in the middle of a stall drops the pending entries.
    present(enc_i(OP_ORI, 5'd0, 5'd14, 16'd1), stalls);
    if_valid = 1'b1;
    if_inst  = enc_r(FN_ADD, 5'd14, 5'd0, 5'd15, 5'd0);
    #1;
    check("rst_stall_pre_ready", if_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_stall_ready", if_ready, 1);
    check("rst_stall_ex_valid", ex_bus.ex_valid, 0);
    tick();
    if_valid = 1'b0;
    check("rst_stall_issue_valid", ex_bus.ex_valid, 1);
    check("rst_stall_issue_rd", ex_bus.ex_rd, 15);

`ifdef ILLEGAL_TRAP_EN
    if_valid = 1'b1;
    if_inst  = {6'h3F, 26'd0};
    #1;
    check("illegal_ready", if_ready, 0);
    tick();
    check("illegal_flag", illegal_inst, 1);
    check("illegal_ex_valid", ex_bus.ex_valid, 0);
    check("illegal_hold_ready", if_ready, 0);
    if_valid = 1'b0;
`else
    present({6'h3F, 26'd0}, stalls);
    check("illegal_stalls", stalls, 0);
    check("illegal_ex_valid", ex_bus.ex_valid, 0);
    check("illegal_flag", illegal_inst, 0);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
